// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC owner issuing single-outstanding imem reads, with a
//            {pc,instr} FIFO toward decode and branch-redirect flush.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc
);

  localparam int               PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int               CNT_W      = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [63:0]      r_pc;
  logic [63:0]      w_pc_next;
  logic [63:0]      r_req_pc;
  logic [63:0]      w_redir_pc;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_fifo_pc    [BUF_DEPTH];
  logic [31:0]      r_fifo_instr [BUF_DEPTH];

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_redir_pc = redirect_pc & ~64'h3;
  // Space test uses the registered count, so a same-cycle pop never frees a slot early.
  assign imem_req   = (r_state == S_FETCH) && (r_count < C_DEPTH);
  assign imem_addr  = r_pc;
  assign w_accept   = imem_req & imem_ready;
  assign id_valid   = (r_count != '0);
  assign w_pop      = id_valid & id_ready;
  assign id_pc      = id_valid ? r_fifo_pc[r_rd_ptr]    : 64'h0;
  assign id_instr   = id_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        if (redirect_valid) begin
          w_pc_next = w_redir_pc;
          if (w_accept) w_state_next = S_DROP;
        end else if (w_accept) begin
          w_pc_next    = r_pc + 64'd4;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_next = S_FETCH;
          if (redirect_valid) w_pc_next = w_redir_pc;
          else                w_push    = 1'b1;
        end else if (redirect_valid) begin
          w_pc_next    = w_redir_pc;
          w_state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect_valid) w_pc_next    = w_redir_pc;
        if (imem_rvalid)    w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC & ~64'h3;
      r_req_pc <= 64'h0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_accept) r_req_pc <= r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_req_pc;
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed vector table plus hand sequences for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [63:0] id_pc;

  int checks   = 0;
  int failures = 0;

  logic        pend = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  logic [63:0] got_pc [$];
  logic [31:0] got_in [$];

  fetch_unit #(.RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [63:0] rpc;
    logic        idr;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_idv;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic rdir, input logic [63:0] rpc, input logic idr,
                              input logic er, input logic [63:0] ea, input logic ev,
                              input logic [63:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rd; v.redir = rdir; v.rpc = rpc; v.idr = idr;
    v.e_req = er; v.e_addr = ea; v.e_idv = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  function automatic logic [31:0] f_instr(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b0;
    pend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle against a one-cycle-latency memory responder; returns sampled req/addr.
  task automatic mstep(input logic rdy, input logic idr,
                       output logic s_req, output logic [63:0] s_addr);
    logic acc;
    imem_ready = rdy; id_ready = idr; redirect_valid = 1'b0;
    imem_rvalid = pend;
    imem_rdata  = pend ? f_instr(pend_addr) : 32'h0;
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    acc    = imem_req & imem_ready;
    if (id_valid && id_ready) begin
      got_pc.push_back(id_pc);
      got_in.push_back(id_instr);
    end
    @(negedge clk);
    pend = acc;
    if (acc) pend_addr = s_addr;
  endtask

  initial begin
    logic        sr;
    logic [63:0] sa;
    bit          done;

    vt[0]  = mk(0, 0, 32'h0,         0, 64'h0,    0,  0, 64'h0,    0, 64'h0,    32'h0);
    vt[1]  = mk(1, 0, 32'h0,         0, 64'h0,    0,  1, 64'h0,    0, 64'h0,    32'h0);
    vt[2]  = mk(0, 1, 32'h0000_0013, 0, 64'h0,    0,  0, 64'h4,    0, 64'h0,    32'h0);
    vt[3]  = mk(1, 0, 32'h0,         0, 64'h0,    1,  1, 64'h4,    1, 64'h0,    32'h0000_0013);
    vt[4]  = mk(0, 1, 32'h0040_0093, 0, 64'h0,    0,  0, 64'h8,    0, 64'h0,    32'h0);
    vt[5]  = mk(1, 0, 32'h0,         0, 64'h0,    1,  1, 64'h8,    1, 64'h4,    32'h0040_0093);
    vt[6]  = mk(0, 0, 32'h0,         1, 64'h1003, 0,  0, 64'hC,    0, 64'h0,    32'h0);
    vt[7]  = mk(0, 1, 32'hDEAD_BEEF, 0, 64'h0,    0,  0, 64'h1000, 0, 64'h0,    32'h0);
    vt[8]  = mk(1, 0, 32'h0,         0, 64'h0,    0,  1, 64'h1000, 0, 64'h0,    32'h0);
    vt[9]  = mk(0, 1, 32'h1111_1111, 0, 64'h0,    0,  0, 64'h1004, 0, 64'h0,    32'h0);
    vt[10] = mk(1, 0, 32'h0,         0, 64'h0,    1,  1, 64'h1004, 1, 64'h1000, 32'h1111_1111);
    vt[11] = mk(0, 1, 32'hBAD0_0008, 1, 64'h2000, 0,  0, 64'h1008, 0, 64'h0,    32'h0);
    vt[12] = mk(1, 0, 32'h0,         0, 64'h0,    0,  1, 64'h2000, 0, 64'h0,    32'h0);
    vt[13] = mk(0, 1, 32'h2222_2222, 0, 64'h0,    0,  0, 64'h2004, 0, 64'h0,    32'h0);
    vt[14] = mk(0, 0, 32'h0,         1, 64'hFFFF_FFFF_FFFF_FFFE, 1,
                1, 64'h2004, 1, 64'h2000, 32'h2222_2222);
    vt[15] = mk(1, 0, 32'h0,         0, 64'h0,    0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0);
    vt[16] = mk(0, 1, 32'hFFFF_0001, 0, 64'h0,    0,  0, 64'h0,    0, 64'h0,    32'h0);
    vt[17] = mk(0, 0, 32'h0,         0, 64'h0,    0,  1, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_0001);
    vt[18] = mk(0, 0, 32'h0,         0, 64'h0,    0,  1, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_0001);

    // Reset state
    #12;
    chk("rst req",   {63'h0, imem_req}, 64'h0);
    chk("rst addr",  imem_addr,         64'h0);
    chk("rst idv",   {63'h0, id_valid}, 64'h0);
    chk("rst idpc",  id_pc,             64'h0);
    chk("rst instr", {32'h0, id_instr}, 64'h0);

    // Streaming, redirect in WAIT / with rvalid / in FETCH, PC wrap
    do_reset();
    for (int i = 0; i < NV; i++) begin
      imem_ready = vt[i].rdy; imem_rvalid = vt[i].rv; imem_rdata = vt[i].rdata;
      redirect_valid = vt[i].redir; redirect_pc = vt[i].rpc; id_ready = vt[i].idr;
      #1;
      chk($sformatf("row%0d req", i),   {63'h0, imem_req}, {63'h0, vt[i].e_req});
      chk($sformatf("row%0d addr", i),  imem_addr,         vt[i].e_addr);
      chk($sformatf("row%0d idv", i),   {63'h0, id_valid}, {63'h0, vt[i].e_idv});
      chk($sformatf("row%0d idpc", i),  id_pc,             vt[i].e_pc);
      chk($sformatf("row%0d instr", i), {32'h0, id_instr}, {32'h0, vt[i].e_instr});
      @(negedge clk);
    end

    // Backpressure: FIFO fills to 2, fetch stalls, then drains in order
    do_reset();
    got_pc.delete(); got_in.delete();
    repeat (5) mstep(1'b1, 1'b0, sr, sa);
    for (int i = 0; i < 3; i++) begin
      mstep(1'b1, 1'b0, sr, sa);
      chk($sformatf("full%0d req", i),  {63'h0, sr}, 64'h0);
      chk($sformatf("full%0d addr", i), sa,          64'h8);
    end
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      mstep(1'b1, 1'b1, sr, sa);
      if (got_pc.size() >= 3) done = 1'b1;
    end
    chk("drain done", {63'h0, done}, 64'h1);
    if (done) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("drain%0d pc", i),    got_pc[i],          64'(i * 4));
        chk($sformatf("drain%0d instr", i), {32'h0, got_in[i]}, {32'h0, f_instr(64'(i * 4))});
      end
    end

    // Stalled request holds address; reset in WAIT; stale rvalid after reset
    do_reset();
    mstep(1'b0, 1'b0, sr, sa);
    for (int i = 0; i < 5; i++) begin
      mstep(1'b0, 1'b0, sr, sa);
      chk($sformatf("stall%0d req", i),  {63'h0, sr}, 64'h1);
      chk($sformatf("stall%0d addr", i), sa,          64'h0);
    end
    mstep(1'b1, 1'b0, sr, sa);
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0;
    #1;
    chk("midrst req",  {63'h0, imem_req}, 64'h0);
    chk("midrst addr", imem_addr,         64'h0);
    chk("midrst idv",  {63'h0, id_valid}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
    #1;
    chk("idle req", {63'h0, imem_req}, 64'h0);
    @(negedge clk);
    #1;
    chk("post req",  {63'h0, imem_req}, 64'h1);
    chk("post addr", imem_addr,         64'h0);
    chk("post idv",  {63'h0, id_valid}, 64'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    chk("post2 idv", {63'h0, id_valid}, 64'h0);
    pend = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
